instr_fetch_issue: RTL and testbench

//  Front end feeding Control_Unit: owns PC, reads instruction memory, and presents decoded fields
//  (operation[3:0], imm, payload) to the decode stage over a valid/ready handshake.

---
 rtl/instr_fetch_issue.sv | 263 ++++++++++++++++++++++++++
 tb/tb_instr_fetch_issue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_issue.sv
// instr_fetch_issue: owns the PC, streams a 1-cycle-latency IMEM into a
// 2-entry buffer and presents the head instruction to decode over valid/ready.
// Redirects from execute clear the buffer and cost one FLUSH cycle.

// Invariant checker for the fetch buffer, instantiated by the top level.
module instr_fetch_issue_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       push,
  input logic       pop,
  input logic [1:0] count,
  input logic       fetch,
  input logic       run
);

  // Credit accounting must keep every returning word inside the two slots
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == 2'd2)));

  // Occupancy never exceeds the physical depth
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    (count <= 2'd2));

  // IMEM is only strobed while actively running
  a_fetch_in_run: assert property (@(posedge clk) disable iff (!rst_n)
    (fetch |-> run));

endmodule

module instr_fetch_issue #(
  parameter int                INSTR_W  = 24,
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [3:0]         operation,
  output logic               imm,
  output logic [INSTR_W-6:0] payload,
  output logic [ADDR_W-1:0]  issue_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int PAY_W = INSTR_W - 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_inflight_pc;

  // Two-slot circular buffer of fetched words and their PCs
  logic [INSTR_W-1:0] r_slot_instr [2];
  logic [ADDR_W-1:0]  r_slot_pc    [2];
  logic               r_rd_ptr;
  logic               w_rd_ptr_nxt;
  logic [1:0]         r_count;
  logic [1:0]         w_count_nxt;

  // Registered copy of the buffer head driving the issue port
  logic               r_issue_valid;
  logic [3:0]         r_operation;
  logic               r_imm;
  logic [PAY_W-1:0]   r_payload;
  logic [ADDR_W-1:0]  r_issue_pc;

  logic               w_run;
  logic               w_flush_now;
  logic               w_pop;
  logic               w_push;
  logic               w_fetch;
  logic               w_wr_idx;
  logic [2:0]         w_occupancy;
  logic               w_head_is_push;
  logic               w_load_head;
  logic [INSTR_W-1:0] w_head_instr;
  logic [ADDR_W-1:0]  w_head_pc;

  assign w_run       = (r_state == ST_RUN);
  // A redirect while running wins over push, pop and fetch this cycle
  assign w_flush_now = w_run & redirect_valid;
  assign w_pop       = (r_count != 2'd0) & issue_ready & ~w_flush_now;
  // The word returning during FLUSH or alongside a redirect is wrong-path
  assign w_push      = r_inflight & (r_state != ST_FLUSH) & ~redirect_valid;
  // A slot freed by this cycle's pop is already usable as fetch credit,
  // which is what lets ready=1 sustain one instruction per cycle
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_fetch     = w_run & ~redirect_valid & (w_occupancy < 3'd2);
  // With at most one valid entry before the push, the free slot follows the head
  assign w_wr_idx    = r_rd_ptr ^ r_count[0];

  assign imem_en     = w_fetch;
  assign imem_addr   = w_fetch ? r_pc : {ADDR_W{1'b0}};

  assign issue_valid = r_issue_valid;
  assign operation   = r_operation;
  assign imm         = r_imm;
  assign payload     = r_payload;
  assign issue_pc    = r_issue_pc;

  // Next state: IDLE waits for start, a redirect in RUN costs one FLUSH cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (redirect_valid) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next PC: redirect target first, otherwise advance (with natural wrap) on fetch
  always_comb begin
    w_pc_nxt = r_pc;
    if (redirect_valid) begin
      w_pc_nxt = redirect_pc;
    end else if (w_fetch) begin
      w_pc_nxt = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // Next occupancy and read pointer of the buffer
  always_comb begin
    w_count_nxt  = r_count;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_flush_now) begin
      w_count_nxt  = 2'd0;
      w_rd_ptr_nxt = 1'b0;
    end else begin
      w_rd_ptr_nxt = r_rd_ptr ^ w_pop;
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 2'd1;
        2'b01:   w_count_nxt = r_count - 2'd1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Select what will sit at the buffer head after this edge
  always_comb begin
    w_head_is_push = w_push & (w_wr_idx == w_rd_ptr_nxt);
    w_head_instr   = r_slot_instr[w_rd_ptr_nxt];
    w_head_pc      = r_slot_pc[w_rd_ptr_nxt];
    if (w_head_is_push) begin
      w_head_instr = imem_rdata;
      w_head_pc    = r_inflight_pc;
    end else begin
      w_head_instr = r_slot_instr[w_rd_ptr_nxt];
      w_head_pc    = r_slot_pc[w_rd_ptr_nxt];
    end
    w_load_head = ~w_flush_now & (w_count_nxt != 2'd0);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC and in-flight tracking of the outstanding IMEM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= {ADDR_W{1'b0}};
    end else begin
      r_pc       <= w_pc_nxt;
      r_inflight <= w_fetch;
      if (w_fetch) begin
        r_inflight_pc <= r_pc;
      end
    end
  end

  // Buffer storage: capture returning words with their PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_slot_instr[i] <= {INSTR_W{1'b0}};
        r_slot_pc[i]    <= {ADDR_W{1'b0}};
      end
    end else if (w_push) begin
      r_slot_instr[w_wr_idx] <= imem_rdata;
      r_slot_pc[w_wr_idx]    <= r_inflight_pc;
    end
  end

  // Buffer pointer and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Issue port registers: follow the head, hold last fields when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_valid <= 1'b0;
      r_operation   <= 4'd0;
      r_imm         <= 1'b0;
      r_payload     <= {PAY_W{1'b0}};
      r_issue_pc    <= {ADDR_W{1'b0}};
    end else begin
      r_issue_valid <= (w_count_nxt != 2'd0);
      if (w_load_head) begin
        r_operation <= w_head_instr[INSTR_W-1:INSTR_W-4];
        r_imm       <= w_head_instr[INSTR_W-5];
        r_payload   <= w_head_instr[PAY_W-1:0];
        r_issue_pc  <= w_head_pc;
      end
    end
  end

  instr_fetch_issue_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .count (r_count),
    .fetch (w_fetch),
    .run   (w_run)
  );

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Bench for instr_fetch_issue: directed latency/stall/redirect/reset/wrap
// checks plus a randomized phase scored against a PC-sequence model.
`timescale 1ns/1ps
module tb_instr_fetch_issue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [23:0] imem_rdata;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  operation;
  logic        imm;
  logic [18:0] payload;
  logic [9:0]  issue_pc;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;

  // Second instance exercising a reset PC near the top of the address space
  logic        wr_start;
  logic        wr_imem_en;
  logic [9:0]  wr_imem_addr;
  logic [23:0] wr_imem_rdata;
  logic        wr_issue_valid;
  logic        wr_ready;
  logic [3:0]  wr_operation;
  logic        wr_imm;
  logic [18:0] wr_payload;
  logic [9:0]  wr_issue_pc;
  logic        wr_redirect_valid;
  logic [9:0]  wr_redirect_pc;

  instr_fetch_issue #(.INSTR_W(24), .ADDR_W(10), .RESET_PC(10'h000)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .operation(operation), .imm(imm), .payload(payload), .issue_pc(issue_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

  instr_fetch_issue #(.INSTR_W(24), .ADDR_W(10), .RESET_PC(10'h3FE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(wr_start), .imem_en(wr_imem_en), .imem_addr(wr_imem_addr),
    .imem_rdata(wr_imem_rdata), .issue_valid(wr_issue_valid), .issue_ready(wr_ready),
    .operation(wr_operation), .imm(wr_imm), .payload(wr_payload), .issue_pc(wr_issue_pc),
    .redirect_valid(wr_redirect_valid), .redirect_pc(wr_redirect_pc));

  // Instruction memory contents shared by both instances
  logic [23:0] mem [1024];

  // 1-cycle-latency IMEM models; unrequested cycles return garbage
  always @(posedge clk) begin
    imem_rdata    <= imem_en    ? mem[imem_addr]    : 24'($urandom);
    wr_imem_rdata <= wr_imem_en ? mem[wr_imem_addr] : 24'($urandom);
  end

  // Reference model: issued stream is mem[pc], mem[pc+1], ... restarted at each redirect
  typedef struct packed {
    logic [9:0]  pc;
    logic [23:0] instr;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        e;
  logic [9:0]  model_pc;
  bit          running;
  int          checks   = 0;
  int          errors   = 0;
  int          n_issued = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back({model_pc, mem[model_pc]});
      model_pc = model_pc + 10'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    top_up();
  endtask

  task automatic restart_model(input logic [9:0] pc);
    exp_q.delete();
    model_pc = pc;
    top_up();
  endtask

  // Monitor: scores every handshake and checks stall/redirect behaviour
  bit          hold_v;
  bit          gap_chk;
  logic [9:0]  hold_pc;
  logic [23:0] hold_instr;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v  = 1'b0;
      gap_chk = 1'b0;
    end else begin
      if (gap_chk) begin
        chk("gap_after_redirect", 32'(issue_valid), 32'd0);
        gap_chk = 1'b0;
      end
      if (hold_v) begin
        chk("hold_valid", 32'(issue_valid), 32'd1);
        chk("hold_pc", 32'(issue_pc), 32'(hold_pc));
        chk("hold_word", 32'({operation, imm, payload}), 32'(hold_instr));
      end
      hold_v = 1'b0;
      if (running && redirect_valid) begin
        gap_chk = 1'b1;
      end else if (issue_valid && issue_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: got pc %0h expected no issue", issue_pc);
        end else begin
          e = exp_q.pop_front();
          chk("issue_pc", 32'(issue_pc), 32'(e.pc));
          chk("issue_word", 32'({operation, imm, payload}), 32'(e.instr));
          n_issued++;
        end
      end else if (issue_valid) begin
        hold_v     = 1'b1;
        hold_pc    = issue_pc;
        hold_instr = {operation, imm, payload};
      end
    end
  end

  task automatic do_redirect(input logic [9:0] tgt);
    bit found;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    restart_model(tgt);
    @(negedge clk);
    chk("redir_no_fetch", 32'(imem_en), 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_fetch", 32'(imem_en), 32'd0);
    tick();
    @(negedge clk);
    chk("refetch_en", 32'(imem_en), 32'd1);
    chk("refetch_addr", 32'(imem_addr), 32'(tgt));
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      @(negedge clk);
      if (issue_valid) found = 1'b1;
    end
    chk("redir_issue_seen", 32'(found), 32'd1);
    if (found) chk("redir_first_pc", 32'(issue_pc), 32'(tgt));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(issue_valid), 32'd0);
    chk({tag, "_imem_en"}, 32'(imem_en), 32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_fields"}, 32'({operation, imm, payload}), 32'd0);
    chk({tag, "_issue_pc"}, 32'(issue_pc), 32'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_r;
    int base;
    rst_n = 1'b0; start = 1'b0; issue_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 10'd0;
    wr_start = 1'b0; wr_ready = 1'b1; wr_redirect_valid = 1'b0; wr_redirect_pc = 10'd0;
    running = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 24'($urandom);
    for (int i = 0; i < 4; i++) mem[i][23:20] = 4'(i);
    mem[10'h3FF][19] = 1'b1;
    restart_model(10'd0);

    @(negedge clk);
    chk_reset_outputs("por");
    tick();
    rst_n = 1'b1;
    tick();

    // T2 stream + T5 wrap: start in cycle 0
    start = 1'b1; wr_start = 1'b1; issue_ready = 1'b1; running = 1'b1;
    @(negedge clk);
    chk("t2_c0_en", 32'(imem_en), 32'd0);
    tick();
    start = 1'b0; wr_start = 1'b0;
    @(negedge clk);
    chk("t2_c1_en", 32'(imem_en), 32'd1);
    chk("t2_c1_addr", 32'(imem_addr), 32'd0);
    chk("t2_c1_valid", 32'(issue_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("t2_c2_valid", 32'(issue_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("t2_valid", 32'(issue_valid), 32'd1);
      chk("t2_pc", 32'(issue_pc), 32'(k));
      chk("t2_op", 32'(operation), 32'(k));
      if (k < 3) begin
        chk("t5_valid", 32'(wr_issue_valid), 32'd1);
        chk("t5_pc", 32'(wr_issue_pc), 32'(10'(10'h3FE + k)));
      end
      if (k == 1) chk("t5_imm", 32'(wr_imm), 32'd1);
    end

    // T6 collision: redirect while the stream pushes and pops every cycle
    do_redirect(10'($urandom_range(16, 1000)));
    // T4 redirect out of a stalled, full buffer
    issue_ready = 1'b0;
    repeat (4) tick();
    do_redirect(10'h040);
    issue_ready = 1'b1;
    repeat (6) tick();

    // T1 reset mid-run with entries buffered
    issue_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    running = 1'b0;
    #1;
    chk_reset_outputs("t1");
    restart_model(10'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_idle_en", 32'(imem_en), 32'd0);
      chk("t1_idle_valid", 32'(issue_valid), 32'd0);
      tick();
    end

    // T3 stall after the first issue
    start = 1'b1; issue_ready = 1'b1; running = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_valid", 32'(issue_valid), 32'd1);
      chk("t3_pc", 32'(issue_pc), 32'd1);
      chk("t3_op", 32'(operation), 32'd1);
      if (i == 7) chk("t3_fetch_stopped", 32'(imem_en), 32'd0);
      tick();
    end
    issue_ready = 1'b1;
    repeat (6) tick();

    // Randomized phase: random backpressure and redirects
    base = n_issued;
    prev_r = 1'b0;
    for (int c = 0; c < 800; c++) begin
      tick();
      issue_ready = ($urandom_range(0, 3) != 0);
      if (!prev_r && ($urandom_range(0, 19) == 0)) begin
        redirect_valid = 1'b1;
        redirect_pc    = 10'($urandom);
        restart_model(redirect_pc);
        prev_r = 1'b1;
      end else begin
        redirect_valid = 1'b0;
        prev_r = 1'b0;
      end
    end
    tick();
    redirect_valid = 1'b0;
    issue_ready = 1'b1;
    repeat (20) tick();
    chk("random_progress", 32'(n_issued - base >= 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
